// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - handshaked multi-cycle data memory responder for the load/store port

module dmem_responder #(
    parameter int AddressWidth = 10,
    parameter int Latency      = 2
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    req_valid_i,
    output logic                    req_ready_o,
    input  logic                    req_wr_i,
    input  logic [AddressWidth-1:0] req_addr_i,
    input  logic [31:0]             req_wr_data_i,
    input  logic [2:0]              req_funct3_i,
    output logic                    rsp_valid_o,
    input  logic                    rsp_ready_i,
    output logic [31:0]             rsp_rd_data_o,
    output logic                    rsp_err_o
);

    localparam int         Depth     = 2 ** (AddressWidth - 2);
    localparam logic [3:0] LoadCount = 4'(Latency - 1);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_e;

    state_e                  state_q, state_d;
    logic [3:0]              cnt_q, cnt_d;
    logic                    wr_q, wr_d;
    logic [AddressWidth-1:0] addr_q, addr_d;
    logic [31:0]             wr_data_q, wr_data_d;
    logic [2:0]              funct3_q, funct3_d;
    logic [31:0]             rd_data_q, rd_data_d;
    logic                    err_q, err_d;

    logic [31:0]             mem_q [Depth];

    // With Latency=1 the commit happens on the acceptance edge, so the access
    // is decoded from the live request in IDLE and from the latched copy otherwise.
    logic                    cur_wr;
    logic [AddressWidth-1:0] cur_addr;
    logic [31:0]             cur_wr_data;
    logic [2:0]              cur_funct3;
    logic                    cur_err;
    logic                    commit;
    logic [3:0]              lane_mask;
    logic [31:0]             lane_data;
    logic [31:0]             rd_word;
    logic [31:0]             rd_shifted;
    logic [15:0]             rd_half;
    logic [31:0]             load_ext;

    assign cur_wr      = (state_q == IDLE) ? req_wr_i      : wr_q;
    assign cur_addr    = (state_q == IDLE) ? req_addr_i    : addr_q;
    assign cur_wr_data = (state_q == IDLE) ? req_wr_data_i : wr_data_q;
    assign cur_funct3  = (state_q == IDLE) ? req_funct3_i  : funct3_q;

    assign commit = ((state_q == IDLE) && req_valid_i && (Latency == 1)) ||
                    ((state_q == WAIT) && (cnt_q == 4'd1));

    assign req_ready_o   = (state_q == IDLE);
    assign rsp_valid_o   = (state_q == RESP);
    assign rsp_rd_data_o = rd_data_q;
    assign rsp_err_o     = err_q;

    // Decode legality, byte-lane write mask and extended load value of the current access
    always_comb begin
        cur_err    = 1'b0;
        lane_mask  = 4'b0000;
        lane_data  = cur_wr_data;
        load_ext   = 32'h0;
        rd_word    = mem_q[cur_addr[AddressWidth-1:2]];
        rd_shifted = rd_word >> {cur_addr[1:0], 3'b000};
        rd_half    = cur_addr[1] ? rd_word[31:16] : rd_word[15:0];
        case (cur_funct3)
            3'b000: begin
                lane_mask = 4'b0001 << cur_addr[1:0];
                lane_data = {4{cur_wr_data[7:0]}};
                load_ext  = {{24{rd_shifted[7]}}, rd_shifted[7:0]};
            end
            3'b001: begin
                cur_err   = cur_addr[0];
                lane_mask = cur_addr[1] ? 4'b1100 : 4'b0011;
                lane_data = {2{cur_wr_data[15:0]}};
                load_ext  = {{16{rd_half[15]}}, rd_half};
            end
            3'b010: begin
                cur_err   = (cur_addr[1:0] != 2'b00);
                lane_mask = 4'b1111;
                load_ext  = rd_word;
            end
            3'b100: begin
                cur_err  = cur_wr;
                load_ext = {24'h0, rd_shifted[7:0]};
            end
            3'b101: begin
                cur_err  = cur_wr | cur_addr[0];
                load_ext = {16'h0, rd_half};
            end
            default: cur_err = 1'b1;
        endcase
    end

    // Next-state logic: latch on acceptance, count down the latency, commit, hold until handshake
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        wr_d      = wr_q;
        addr_d    = addr_q;
        wr_data_d = wr_data_q;
        funct3_d  = funct3_q;
        rd_data_d = rd_data_q;
        err_d     = err_q;
        case (state_q)
            IDLE: begin
                if (req_valid_i) begin
                    wr_d      = req_wr_i;
                    addr_d    = req_addr_i;
                    wr_data_d = req_wr_data_i;
                    funct3_d  = req_funct3_i;
                    cnt_d     = LoadCount;
                    state_d   = (Latency == 1) ? RESP : WAIT;
                end
            end
            WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                if (rsp_ready_i) begin
                    state_d   = IDLE;
                    rd_data_d = 32'h0;
                    err_d     = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
        if (commit) begin
            err_d     = cur_err;
            rd_data_d = (cur_err || cur_wr) ? 32'h0 : load_ext;
        end
    end

    // Control and response registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            cnt_q     <= 4'd0;
            wr_q      <= 1'b0;
            addr_q    <= '0;
            wr_data_q <= 32'h0;
            funct3_q  <= 3'b000;
            rd_data_q <= 32'h0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            wr_q      <= wr_d;
            addr_q    <= addr_d;
            wr_data_q <= wr_data_d;
            funct3_q  <= funct3_d;
            rd_data_q <= rd_data_d;
            err_q     <= err_d;
        end
    end

    // Word storage with byte-lane writes; not cleared by reset, but a reset edge suppresses the commit
    always_ff @(posedge clk_i) begin
        if (!rst_i && commit && cur_wr && !cur_err) begin
            for (int i = 0; i < 4; i++) begin
                if (lane_mask[i]) begin
                    mem_q[cur_addr[AddressWidth-1:2]][8*i +: 8] <= lane_data[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - directed self-checking bench for dmem_responder

module tb_dmem_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_wr;
    logic [9:0]  req_addr;
    logic [31:0] req_wr_data;
    logic [2:0]  req_funct3;
    logic        rsp_ready;

    logic        req_ready2, rsp_valid2, rsp_err2;
    logic [31:0] rsp_rd_data2;
    logic        req_ready1, rsp_valid1, rsp_err1;
    logic [31:0] rsp_rd_data1;

    logic        use_l1 = 1'b0;
    logic        req_ready, rsp_valid, rsp_err;
    logic [31:0] rsp_rd_data;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    assign req_ready   = use_l1 ? req_ready1   : req_ready2;
    assign rsp_valid   = use_l1 ? rsp_valid1   : rsp_valid2;
    assign rsp_err     = use_l1 ? rsp_err1     : rsp_err2;
    assign rsp_rd_data = use_l1 ? rsp_rd_data1 : rsp_rd_data2;

    dmem_responder #(.AddressWidth(10), .Latency(2)) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .req_valid_i   (req_valid),
        .req_ready_o   (req_ready2),
        .req_wr_i      (req_wr),
        .req_addr_i    (req_addr),
        .req_wr_data_i (req_wr_data),
        .req_funct3_i  (req_funct3),
        .rsp_valid_o   (rsp_valid2),
        .rsp_ready_i   (rsp_ready),
        .rsp_rd_data_o (rsp_rd_data2),
        .rsp_err_o     (rsp_err2)
    );

    dmem_responder #(.AddressWidth(10), .Latency(1)) dut_l1 (
        .clk_i         (clk),
        .rst_i         (rst),
        .req_valid_i   (req_valid),
        .req_ready_o   (req_ready1),
        .req_wr_i      (req_wr),
        .req_addr_i    (req_addr),
        .req_wr_data_i (req_wr_data),
        .req_funct3_i  (req_funct3),
        .rsp_valid_o   (rsp_valid1),
        .rsp_ready_i   (rsp_ready),
        .rsp_rd_data_o (rsp_rd_data1),
        .rsp_err_o     (rsp_err1)
    );

    // Issue one request, wait for its response, capture it and complete the handshake.
    // lat counts clock edges from acceptance to the first cycle with rsp_valid high.
    task automatic do_access(input logic wr, input logic [9:0] addr, input logic [31:0] data,
                             input logic [2:0] f3, output logic [31:0] rd, output logic err,
                             output int lat);
        int n;
        @(negedge clk);
        req_valid   = 1'b1;
        req_wr      = wr;
        req_addr    = addr;
        req_wr_data = data;
        req_funct3  = f3;
        n = 0;
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        req_valid = 1'b0;
        lat = 1;
        while (!rsp_valid && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        if (n >= 50) lat = 99;
        rd = rsp_rd_data;
        err = rsp_err;
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        checks++;
        if (req_ready !== 1'b1) begin failures++; $display("FAIL reset_req_ready got %b want 1", req_ready); end
        checks++;
        if (rsp_valid !== 1'b0) begin failures++; $display("FAIL reset_rsp_valid got %b want 0", rsp_valid); end
        checks++;
        if (rsp_rd_data !== 32'h0) begin failures++; $display("FAIL reset_rd_data got %h want 00000000", rsp_rd_data); end
        checks++;
        if (rsp_err !== 1'b0) begin failures++; $display("FAIL reset_err got %b want 0", rsp_err); end
    endtask

    task automatic test_word;
        logic [31:0] rd;
        logic        err;
        int          lat;
        do_access(1'b1, 10'h010, 32'hDEADBEEF, 3'b010, rd, err, lat);
        checks++;
        if (lat != 2) begin failures++; $display("FAIL sw_latency got %0d want 2", lat); end
        checks++;
        if (rd !== 32'h0 || err !== 1'b0) begin failures++; $display("FAIL sw_rsp got %h/%b want 00000000/0", rd, err); end
        checks++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || rsp_rd_data !== 32'h0) begin
            failures++;
            $display("FAIL post_handshake got valid=%b ready=%b data=%h want 0/1/0", rsp_valid, req_ready, rsp_rd_data);
        end
        do_access(1'b0, 10'h010, 32'h0, 3'b010, rd, err, lat);
        checks++;
        if (lat != 2) begin failures++; $display("FAIL lw_latency got %0d want 2", lat); end
        checks++;
        if (rd !== 32'hDEADBEEF || err !== 1'b0) begin failures++; $display("FAIL lw_data got %h/%b want deadbeef/0", rd, err); end
    endtask

    task automatic test_extend;
        logic [31:0] rd;
        logic        err;
        int          lat;
        do_access(1'b0, 10'h013, 32'h0, 3'b000, rd, err, lat);
        checks++;
        if (rd !== 32'hFFFFFFDE || err !== 1'b0) begin failures++; $display("FAIL lb got %h/%b want ffffffde/0", rd, err); end
        do_access(1'b0, 10'h013, 32'h0, 3'b100, rd, err, lat);
        checks++;
        if (rd !== 32'h000000DE || err !== 1'b0) begin failures++; $display("FAIL lbu got %h/%b want 000000de/0", rd, err); end
        do_access(1'b0, 10'h012, 32'h0, 3'b001, rd, err, lat);
        checks++;
        if (rd !== 32'hFFFFDEAD || err !== 1'b0) begin failures++; $display("FAIL lh got %h/%b want ffffdead/0", rd, err); end
        do_access(1'b0, 10'h010, 32'h0, 3'b101, rd, err, lat);
        checks++;
        if (rd !== 32'h0000BEEF || err !== 1'b0) begin failures++; $display("FAIL lhu got %h/%b want 0000beef/0", rd, err); end
        do_access(1'b0, 10'h011, 32'h0, 3'b000, rd, err, lat);
        checks++;
        if (rd !== 32'hFFFFFFBE) begin failures++; $display("FAIL lb_lane1 got %h want ffffffbe", rd); end
    endtask

    task automatic test_partial_store;
        logic [31:0] rd;
        logic        err;
        int          lat;
        do_access(1'b1, 10'h011, 32'hAAAAAA55, 3'b000, rd, err, lat);
        do_access(1'b0, 10'h010, 32'h0, 3'b010, rd, err, lat);
        checks++;
        if (rd !== 32'hDEAD55EF) begin failures++; $display("FAIL sb_lane1 got %h want dead55ef", rd); end
        do_access(1'b1, 10'h012, 32'hBBBB1234, 3'b001, rd, err, lat);
        do_access(1'b0, 10'h010, 32'h0, 3'b010, rd, err, lat);
        checks++;
        if (rd !== 32'h123455EF) begin failures++; $display("FAIL sh_upper got %h want 123455ef", rd); end
    endtask

    task automatic test_errors;
        logic [31:0] rd;
        logic        err;
        int          lat;
        do_access(1'b1, 10'h011, 32'hFFFFFFFF, 3'b001, rd, err, lat);
        checks++;
        if (rd !== 32'h0 || err !== 1'b1) begin failures++; $display("FAIL sh_misaligned got %h/%b want 00000000/1", rd, err); end
        do_access(1'b0, 10'h012, 32'h0, 3'b010, rd, err, lat);
        checks++;
        if (rd !== 32'h0 || err !== 1'b1) begin failures++; $display("FAIL lw_misaligned got %h/%b want 00000000/1", rd, err); end
        do_access(1'b1, 10'h010, 32'hFFFFFFFF, 3'b100, rd, err, lat);
        checks++;
        if (err !== 1'b1) begin failures++; $display("FAIL store_f3_100 got err=%b want 1", err); end
        do_access(1'b0, 10'h010, 32'h0, 3'b011, rd, err, lat);
        checks++;
        if (rd !== 32'h0 || err !== 1'b1) begin failures++; $display("FAIL load_f3_011 got %h/%b want 00000000/1", rd, err); end
        do_access(1'b0, 10'h011, 32'h0, 3'b101, rd, err, lat);
        checks++;
        if (err !== 1'b1) begin failures++; $display("FAIL lhu_misaligned got err=%b want 1", err); end
        do_access(1'b0, 10'h010, 32'h0, 3'b010, rd, err, lat);
        checks++;
        if (rd !== 32'h123455EF || err !== 1'b0) begin failures++; $display("FAIL word_after_errors got %h/%b want 123455ef/0", rd, err); end
    endtask

    task automatic test_backpressure;
        int          n;
        logic [31:0] held;
        @(negedge clk);
        req_valid  = 1'b1;
        req_wr     = 1'b0;
        req_addr   = 10'h010;
        req_funct3 = 3'b010;
        @(negedge clk);
        req_addr   = 10'h011;
        req_funct3 = 3'b100;
        n = 0;
        while (!rsp_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (rsp_valid !== 1'b1 || rsp_rd_data !== 32'h123455EF) begin
            failures++;
            $display("FAIL bp_first_rsp got valid=%b data=%h want 1/123455ef", rsp_valid, rsp_rd_data);
        end
        held = rsp_rd_data;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (rsp_valid !== 1'b1 || rsp_rd_data !== 32'h123455EF || req_ready !== 1'b0) begin
                failures++;
                $display("FAIL bp_hold%0d got valid=%b data=%h ready=%b want 1/123455ef/0", i, rsp_valid, rsp_rd_data, req_ready);
            end
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        checks++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
            failures++;
            $display("FAIL bp_release got ready=%b valid=%b want 1/0", req_ready, rsp_valid);
        end
        @(negedge clk);
        req_valid = 1'b0;
        checks++;
        if (req_ready !== 1'b0) begin failures++; $display("FAIL bp_second_accept got ready=%b want 0", req_ready); end
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b1 || rsp_rd_data !== 32'h00000055 || rsp_err !== 1'b0) begin
            failures++;
            $display("FAIL bp_second_rsp got valid=%b data=%h err=%b want 1/00000055/0", rsp_valid, rsp_rd_data, rsp_err);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        checks++;
        if (held !== 32'h123455EF) begin failures++; $display("FAIL bp_held_value got %h want 123455ef", held); end
    endtask

    task automatic test_reset_mid;
        logic [31:0] rd;
        logic        err;
        int          lat;
        do_access(1'b1, 10'h020, 32'h0, 3'b010, rd, err, lat);
        @(negedge clk);
        req_valid   = 1'b1;
        req_wr      = 1'b1;
        req_addr    = 10'h020;
        req_wr_data = 32'h12345678;
        req_funct3  = 3'b010;
        @(negedge clk);
        req_valid = 1'b0;
        checks++;
        if (req_ready !== 1'b0) begin failures++; $display("FAIL rst_wait_state got ready=%b want 0", req_ready); end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_rd_data !== 32'h0 || rsp_err !== 1'b0) begin
            failures++;
            $display("FAIL rst_in_wait got ready=%b valid=%b data=%h err=%b want 1/0/0/0", req_ready, rsp_valid, rsp_rd_data, rsp_err);
        end
        do_access(1'b0, 10'h020, 32'h0, 3'b010, rd, err, lat);
        checks++;
        if (rd !== 32'h0 || err !== 1'b0) begin failures++; $display("FAIL rst_dropped_store got %h/%b want 00000000/0", rd, err); end
        @(negedge clk);
        req_valid  = 1'b1;
        req_wr     = 1'b0;
        req_addr   = 10'h010;
        req_funct3 = 3'b010;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b1) begin failures++; $display("FAIL rst_resp_setup got valid=%b want 1", rsp_valid); end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_rd_data !== 32'h0) begin
            failures++;
            $display("FAIL rst_in_resp got ready=%b valid=%b data=%h want 1/0/0", req_ready, rsp_valid, rsp_rd_data);
        end
    endtask

    task automatic test_latency1;
        logic [31:0] rd;
        logic        err;
        int          lat;
        use_l1 = 1'b1;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        do_access(1'b1, 10'h020, 32'hCAFEF00D, 3'b010, rd, err, lat);
        checks++;
        if (lat != 1) begin failures++; $display("FAIL l1_sw_latency got %0d want 1", lat); end
        do_access(1'b0, 10'h020, 32'h0, 3'b010, rd, err, lat);
        checks++;
        if (lat != 1 || rd !== 32'hCAFEF00D) begin failures++; $display("FAIL l1_lw got lat=%0d data=%h want 1/cafef00d", lat, rd); end
        do_access(1'b0, 10'h022, 32'h0, 3'b001, rd, err, lat);
        checks++;
        if (rd !== 32'hFFFFCAFE || err !== 1'b0) begin failures++; $display("FAIL l1_lh got %h/%b want ffffcafe/0", rd, err); end
        do_access(1'b0, 10'h021, 32'h0, 3'b010, rd, err, lat);
        checks++;
        if (rd !== 32'h0 || err !== 1'b1) begin failures++; $display("FAIL l1_lw_misaligned got %h/%b want 00000000/1", rd, err); end
    endtask

    initial begin
        rst         = 1'b1;
        req_valid   = 1'b0;
        req_wr      = 1'b0;
        req_addr    = 10'h0;
        req_wr_data = 32'h0;
        req_funct3  = 3'b000;
        rsp_ready   = 1'b0;
        test_reset();
        test_word();
        test_extend();
        test_partial_store();
        test_errors();
        test_backpressure();
        test_reset_mid();
        test_latency1();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
